inst_aligner: RTL and testbench
===============================

INST_ALIGNER -- requirements
Module: inst_aligner

Interface
REQ-001 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst_n, input, 1 bit: synchronous, active-low reset, sampled on the rising edge of clk.
REQ-003 SHALL have port icache_req, output, 1 bit: fetch request to the I-cache.
REQ-004 SHALL have port icache_addr, output, 30 bits: word address of the fetch (byte address [31:2]).
REQ-005 SHALL have port icache_rdata, input, 32 bits: fetched word, little-endian halfwords, valid when accepted.
REQ-006 SHALL have port icache_stall, input, 1 bit: high means the I-cache is not delivering data this cycle.
REQ-007 SHALL have port out_valid, output, 1 bit: a complete instruction is presented to decode.
REQ-008 SHALL have port out_inst, output, 32 bits: raw instruction; when compressed, the 16-bit parcel sits in [15:0] and [31:16] is zero.
REQ-009 SHALL have port out_is_c, output, 1 bit: out_inst is a 16-bit compressed parcel (head halfword [1:0] != 2'b11).
REQ-010 SHALL have port out_pc, output, 32 bits: byte address of out_inst, bit 0 always 0.
REQ-011 SHALL have port out_ready, input, 1 bit: decode accepts out_inst this cycle; low means decode is stalled.
REQ-012 SHALL have port redirect, input, 1 bit: branch or jump taken; flush and refetch.
REQ-013 SHALL have port redirect_pc, input, 32 bits: halfword-aligned target address.

Function
REQ-014 SHALL hold a 4-entry halfword queue with a 3-bit count, a head PC, a 30-bit fetch word pointer fptr and a skip flag.
REQ-015 SHALL compute icache_req = (count <= 2) && !redirect, and SHALL drive icache_addr = fptr.
REQ-016 SHALL accept a word on any edge with icache_req && !icache_stall, and SHALL then increment fptr by 1, wrapping modulo 2^30.
REQ-017 SHALL, on each accepted word, push 2 halfwords (low half first), or only the high half when skip = 1; skip SHALL clear after that first accepted word.
REQ-018 SHALL compute out_valid combinationally from registered state: 1 when count >= 1 and the head is compressed, or when count >= 2 and the head is 32-bit; 0 otherwise.
REQ-019 SHALL form a 32-bit out_inst as {queue[1], queue[0]}.
REQ-020 SHALL pop on out_valid && out_ready: 1 halfword when compressed, 2 otherwise; head PC SHALL advance by 2 or 4 respectively.
REQ-021 SHALL, on a simultaneous push and pop in one cycle, set count = count + pushed - popped and preserve halfword order; count SHALL never exceed 4.
REQ-022 SHALL, when out_ready is low, leave out_inst, out_pc, out_is_c and out_valid unchanged except through pushes, and SHALL never drop or reorder halfwords.
REQ-023 SHALL, when a 32-bit instruction straddles two words and only one halfword is queued, keep out_valid at 0 until the second word is pushed.
REQ-024 SHALL give redirect highest priority: on that edge, count <- 0, head PC <- redirect_pc, fptr <- redirect_pc[31:2], skip <- redirect_pc[1].
REQ-025 SHALL, on a redirect edge, perform no push and no pop, discarding any word returned that cycle, and SHALL force out_valid to 0 during the redirect cycle.
REQ-026 SHALL present the first instruction after a redirect or reset no earlier than 1 cycle after the first accepted word.

Reset
REQ-027 SHALL, when rst_n = 0 at an edge, set count = 0, head PC = 0, fptr = 0 and skip = 0, giving out_valid = 0, out_inst = 0, out_is_c = 0, out_pc = 0, and icache_addr = 0.
REQ-028 SHALL let reset override redirect and any in-flight accepted word; icache_req SHALL be 1 in the first cycle after reset release.

Verification
REQ-029 SHALL verify this case: after reset, icache delivers 0x00000013 then 0x00100093 with no stall; out_pc SHALL read 0x0 then 0x4, out_is_c SHALL be 0, and icache_addr SHALL read 0, 1, 2.
REQ-030 SHALL verify this case: word0 = 0x00130001 and word1 = 0xABCD0000; output 1 SHALL be pc 0x0, inst 0x00000001, is_c = 1, and output 2 SHALL be pc 0x2, inst 0x00000013, is_c = 0, valid only after word1 is accepted.
REQ-031 SHALL verify this case: redirect with redirect_pc = 0x00000106 while the queue is full; the next icache_addr SHALL be 0x41, the low half of word 0x104 SHALL be discarded, and the first out_pc SHALL be 0x106.
REQ-032 SHALL verify this case: out_ready held low for 3 cycles with the queue filling; outputs SHALL stay stable, icache_req SHALL drop once count = 3 or 4, and the sequence SHALL resume intact with no loss.
REQ-033 SHALL verify this case: icache_stall held high for 4 cycles; icache_addr SHALL be held, out_valid SHALL go to 0 once the queue drains, and fetch SHALL resume at the same address.
REQ-034 SHALL verify this case: redirect coincides with an accepted word and a pop; the word SHALL be dropped, out_valid SHALL be 0 that cycle, and reset asserted mid-stream SHALL restore all REQ-027 values on the next edge.

Source files
------------

// File: rtl/inst_aligner.sv
// inst_aligner: turns a stream of 32-bit I-cache words into whole RISC-V
// instructions (16-bit compressed or 32-bit) for decode.
// A 4-entry halfword queue sits between fetch and decode. Fetch runs ahead
// while at least two halfword slots are free. Decode takes one instruction
// per cycle.
// Ports:
//   clk, rst_n               clock, synchronous active-low reset
//   icache_req/icache_addr   fetch request and word address (byte addr [31:2])
//   icache_rdata             fetched word, taken when icache_req && !icache_stall
//   icache_stall             I-cache not delivering this cycle
//   out_valid/out_inst       complete instruction to decode
//   out_is_c/out_pc          compressed flag and byte PC of out_inst
//   out_ready                decode accepts out_inst this cycle
//   redirect/redirect_pc     taken branch/jump: flush and refetch from target
module inst_aligner (
  input  logic        clk,
  input  logic        rst_n,
  output logic        icache_req,
  output logic [29:0] icache_addr,
  input  logic [31:0] icache_rdata,
  input  logic        icache_stall,
  output logic        out_valid,
  output logic [31:0] out_inst,
  output logic        out_is_c,
  output logic [31:0] out_pc,
  input  logic        out_ready,
  input  logic        redirect,
  input  logic [31:0] redirect_pc
);

  localparam int unsigned HW_W   = 16;
  localparam int unsigned DEPTH  = 4;
  localparam int unsigned CNT_W  = 3;
  localparam int unsigned FPTR_W = 30;

  logic [HW_W-1:0]   q [DEPTH];
  logic [HW_W-1:0]   q_nxt [DEPTH];
  logic [CNT_W-1:0]  count;
  logic [31:0]       head_pc;
  logic [FPTR_W-1:0] fptr;
  logic              skip;

  logic              head_c;
  logic              head_complete;
  logic              accept;
  logic              pop;
  logic [CNT_W-1:0]  pop_n;
  logic [CNT_W-1:0]  push_n;
  logic [CNT_W-1:0]  src;
  logic [1:0]        wr0;
  logic [1:0]        wr1;

  // Head decode and handshake terms.
  always_comb begin
    head_c        = (q[0][1:0] != 2'b11);
    head_complete = ((count >= 3'd1) && head_c) || ((count >= 3'd2) && !head_c);
    out_valid     = head_complete && !redirect;
    out_is_c      = (count != 3'd0) && head_c;
    out_inst      = head_c ? {16'h0000, q[0]} : {q[1], q[0]};
    out_pc        = head_pc;
    icache_req    = (count <= 3'd2) && !redirect;
    icache_addr   = fptr;
    accept        = icache_req && !icache_stall;
    pop           = out_valid && out_ready;
    pop_n         = pop ? (head_c ? 3'd1 : 3'd2) : 3'd0;
    push_n        = accept ? (skip ? 3'd1 : 3'd2) : 3'd0;
  end

  // Next queue contents: shift out popped halfwords, then append pushed ones
  // behind the survivors so order is preserved on simultaneous push/pop.
  always_comb begin
    src = '0;
    wr0 = 2'(count - pop_n);
    wr1 = wr0 + 2'd1;
    for (int i = 0; i < DEPTH; i++) begin
      src      = 3'(i) + pop_n;
      q_nxt[i] = (src < 3'(DEPTH)) ? q[src[1:0]] : q[i];
    end
    if (accept) begin
      if (skip) begin
        q_nxt[wr0] = icache_rdata[31:16];
      end else begin
        q_nxt[wr0] = icache_rdata[15:0];
        q_nxt[wr1] = icache_rdata[31:16];
      end
    end
  end

  // State update; reset beats redirect, redirect beats push/pop.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count   <= '0;
      head_pc <= '0;
      fptr    <= '0;
      skip    <= 1'b0;
      for (int i = 0; i < DEPTH; i++) q[i] <= '0;
    end else if (redirect) begin
      count   <= '0;
      head_pc <= redirect_pc;
      fptr    <= redirect_pc[31:2];
      skip    <= redirect_pc[1];
    end else begin
      count   <= count + push_n - pop_n;
      head_pc <= head_pc + {28'd0, pop_n, 1'b0};
      for (int i = 0; i < DEPTH; i++) q[i] <= q_nxt[i];
      if (accept) begin
        fptr <= fptr + 30'd1;
        skip <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_inst_aligner.sv
// tb_inst_aligner: directed bench for inst_aligner. A word memory plays the
// I-cache; on every reset/redirect the expected instruction stream is built
// from that memory and queued, then checked in order as decode takes it.
module tb_inst_aligner;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        icache_req;
  logic [29:0] icache_addr;
  logic [31:0] icache_rdata;
  logic        icache_stall;
  logic        out_valid;
  logic [31:0] out_inst;
  logic        out_is_c;
  logic [31:0] out_pc;
  logic        out_ready;
  logic        redirect;
  logic [31:0] redirect_pc;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        c;
  } exp_t;

  logic [31:0] mem [256];
  exp_t        sb [$];
  int          tests = 0;
  int          fails = 0;
  int          n_out = 0;
  logic [31:0] s_pc, s_inst;
  logic        s_c;
  logic [29:0] s_addr;

  always #5 clk = ~clk;

  inst_aligner dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .icache_req   (icache_req),
    .icache_addr  (icache_addr),
    .icache_rdata (icache_rdata),
    .icache_stall (icache_stall),
    .out_valid    (out_valid),
    .out_inst     (out_inst),
    .out_is_c     (out_is_c),
    .out_pc       (out_pc),
    .out_ready    (out_ready),
    .redirect     (redirect),
    .redirect_pc  (redirect_pc)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    tests++;
    assert (obs === exp_v) else begin
      fails++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp_v);
    end
  endtask

  function automatic logic [15:0] hw_at(input logic [31:0] pc);
    logic [31:0] w;
    w = mem[pc[9:2]];
    return pc[1] ? w[31:16] : w[15:0];
  endfunction

  // Rebuild the expected stream starting at pc from the memory image.
  task automatic restart(input logic [31:0] pc);
    logic [31:0] p;
    logic [15:0] h0;
    sb.delete();
    p = pc;
    repeat (64) begin
      h0 = hw_at(p);
      if (h0[1:0] != 2'b11) begin
        sb.push_back('{pc: p, inst: {16'h0000, h0}, c: 1'b1});
        p = p + 32'd2;
      end else begin
        sb.push_back('{pc: p, inst: {hw_at(p + 32'd2), h0}, c: 1'b0});
        p = p + 32'd4;
      end
    end
  endtask

  // One cycle: drive inputs after negedge, serve the fetch, score any handoff.
  task automatic cyc(input logic rst, input logic rdy, input logic stl,
                     input logic redir, input logic [31:0] rpc);
    exp_t e;
    @(negedge clk);
    rst_n = rst; out_ready = rdy; icache_stall = stl;
    redirect = redir; redirect_pc = rpc;
    #1 icache_rdata = mem[icache_addr[7:0]];
    #1;
    if (rst_n && out_valid && out_ready) begin
      n_out++;
      if (sb.size() == 0) begin
        chk("sb_underflow", 32'(sb.size()), 32'd1);
      end else begin
        e = sb.pop_front();
        chk("sb_pc", out_pc, e.pc);
        chk("sb_inst", out_inst, e.inst);
        chk("sb_is_c", 32'(out_is_c), 32'(e.c));
      end
    end
  endtask

  task automatic go();
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; out_ready = 1'b0; icache_stall = 1'b0;
    redirect = 1'b0; redirect_pc = '0; icache_rdata = '0;
    for (int i = 0; i < 256; i++) mem[i] = $urandom;
    mem[0]    = 32'h0000_0013;
    mem[1]    = 32'h0010_0093;
    mem[8'h41] = 32'h0002_0001;

    // Reset values
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 32'd0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 32'd0);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_inst", out_inst, 32'd0);
    chk("rst_is_c", 32'(out_is_c), 32'd0);
    chk("rst_pc", out_pc, 32'd0);
    chk("rst_addr", 32'(icache_addr), 32'd0);

    // Two aligned 32-bit instructions
    restart(32'd0);
    go();
    chk("a_req", 32'(icache_req), 32'd1);
    chk("a_addr0", 32'(icache_addr), 32'd0);
    chk("a_valid0", 32'(out_valid), 32'd0);
    go();
    chk("a_addr1", 32'(icache_addr), 32'd1);
    chk("a_pc0", out_pc, 32'h0);
    chk("a_inst0", out_inst, 32'h0000_0013);
    chk("a_c0", 32'(out_is_c), 32'd0);
    go();
    chk("a_addr2", 32'(icache_addr), 32'd2);
    chk("a_pc1", out_pc, 32'h4);
    chk("a_inst1", out_inst, 32'h0010_0093);
    chk("a_c1", 32'(out_is_c), 32'd0);
    repeat (4) go();

    // Decode stalled three cycles: queue fills, fetch stops, outputs hold
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
    chk("b_valid", 32'(out_valid), 32'd1);
    chk("b_req_drop", 32'(icache_req), 32'd0);
    s_pc = out_pc; s_inst = out_inst; s_c = out_is_c;
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
    chk("b_req_drop2", 32'(icache_req), 32'd0);
    chk("b_valid_hold", 32'(out_valid), 32'd1);
    chk("b_pc_hold", out_pc, s_pc);
    chk("b_inst_hold", out_inst, s_inst);
    chk("b_c_hold", 32'(out_is_c), 32'(s_c));
    repeat (6) go();

    // Compressed then a 32-bit instruction straddling two words
    mem[0] = 32'h0013_0001;
    mem[1] = 32'hABCD_0000;
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 32'd0);
    restart(32'd0);
    go();
    chk("c_valid0", 32'(out_valid), 32'd0);
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 32'd0);
    chk("c_valid1", 32'(out_valid), 32'd1);
    chk("c_pc1", out_pc, 32'h0);
    chk("c_inst1", out_inst, 32'h0000_0001);
    chk("c_c1", 32'(out_is_c), 32'd1);
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 32'd0);
    chk("c_straddle", 32'(out_valid), 32'd0);
    go();
    chk("c_wait", 32'(out_valid), 32'd0);
    chk("c_addr1", 32'(icache_addr), 32'd1);
    go();
    chk("c_pc2", out_pc, 32'h2);
    chk("c_inst2", out_inst, 32'h0000_0013);
    chk("c_c2", 32'(out_is_c), 32'd0);
    repeat (2) go();

    // Redirect to an odd halfword while the queue is full
    repeat (3) cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
    chk("d_full_req", 32'(icache_req), 32'd0);
    cyc(1'b1, 1'b1, 1'b0, 1'b1, 32'h0000_0106);
    chk("d_redir_valid", 32'(out_valid), 32'd0);
    chk("d_redir_req", 32'(icache_req), 32'd0);
    restart(32'h0000_0106);
    go();
    chk("d_addr", 32'(icache_addr), 32'h41);
    chk("d_valid0", 32'(out_valid), 32'd0);
    go();
    chk("d_pc", out_pc, 32'h106);
    chk("d_inst", out_inst, 32'h0000_0002);
    chk("d_c", 32'(out_is_c), 32'd1);
    repeat (4) go();

    // I-cache stall for four cycles
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 32'd0);
    s_addr = icache_addr;
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 32'd0);
    chk("e_hold1", 32'(icache_addr), 32'(s_addr));
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 32'd0);
    chk("e_hold2", 32'(icache_addr), 32'(s_addr));
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 32'd0);
    chk("e_hold3", 32'(icache_addr), 32'(s_addr));
    chk("e_drained", 32'(out_valid), 32'd0);
    go();
    chk("e_resume_addr", 32'(icache_addr), 32'(s_addr));
    chk("e_resume_req", 32'(icache_req), 32'd1);
    go();
    chk("e_next_addr", 32'(icache_addr), 32'(s_addr + 30'd1));
    repeat (4) go();

    // Redirect while a word returns and decode is ready
    cyc(1'b1, 1'b1, 1'b0, 1'b1, 32'h0000_0200);
    chk("f_valid", 32'(out_valid), 32'd0);
    chk("f_req", 32'(icache_req), 32'd0);
    restart(32'h0000_0200);
    go();
    chk("f_addr", 32'(icache_addr), 32'h80);
    chk("f_valid0", 32'(out_valid), 32'd0);
    go();
    chk("f_pc", out_pc, 32'h200);
    repeat (4) go();

    // Reset mid-stream overrides a coincident redirect
    cyc(1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_0300);
    restart(32'd0);
    go();
    chk("g_valid", 32'(out_valid), 32'd0);
    chk("g_inst", out_inst, 32'd0);
    chk("g_is_c", 32'(out_is_c), 32'd0);
    chk("g_pc", out_pc, 32'd0);
    chk("g_addr", 32'(icache_addr), 32'd0);
    chk("g_req", 32'(icache_req), 32'd1);
    repeat (4) go();
    chk("g_first_pc", 32'(n_out > 0), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
